mult8_seq_ctrl: RTL and testbench
=================================

Name: mult8_seq_ctrl

Overview:
- Sequential controller that computes an unsigned 8x8 -> 16-bit product.
- It time-multiplexes a single instance of the existing 4x4 combinational multiplier core (module main) over up to four nibble steps.
- It accumulates the shifted partial products and returns the result over a valid/ready handshake.
- It sits between an upstream operand producer and a downstream consumer and lets the datapath reuse the small core instead of building a full 8x8 array.

Parameters:
- SHORT_EN, 1, when 1 a single-step fast path is used if both operand upper nibbles are zero; when 0 every operation takes four steps.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- in_a  input  8  multiplicand, unsigned
- in_b  input  8  multiplier, unsigned
- out_valid  output  1  out_p holds a completed product
- out_ready  input  1  consumer accepts product
- out_p  output  16  product in_a*in_b
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-operation:
  - state=IDLE, step=0, acc=0, out_p=0, out_valid=0, busy=0; the in-flight operation is discarded.
  - in_ready is decoded from state, so it is 1 in the first cycle after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a/in_b into op_a/op_b, clear acc, step=0, go to RUN.
  - If SHORT_EN=1 and in_a[7:4]==0 and in_b[7:4]==0, set the short flag.
- RUN: each cycle the core is driven combinationally from the latched operands, selected by step:
  - step0: a[3:0]*b[3:0], shift 0
  - step1: a[3:0]*b[7:4], shift 4
  - step2: a[7:4]*b[3:0], shift 4
  - step3: a[7:4]*b[7:4], shift 8
- acc <= acc + (pp << shift), truncated to 16 bits. The mathematically exact sum never exceeds 0xFE01, so there is no overflow.
- RUN exit:
  - Last step (step3, or step0 when short=1): out_p <= final sum, out_valid <= 1, go to DONE.
  - Otherwise step increments.
- DONE: out_valid=1 and out_p held stable. On out_ready go to IDLE with out_valid=0 on the next cycle.
- Latency, with the accept at edge T:
  - Full path: out_valid rises after edge T+4.
  - Short path: out_valid rises after edge T+1.
  - Minimum initiation interval is 6 cycles (full) or 3 cycles (short). There is no accept in DONE.
- in_valid while not in IDLE is ignored; operands are not captured. The upstream producer must hold its data per the valid/ready rule.
- out_ready while out_valid=0 has no effect.
- Back-pressure: DONE may last indefinitely, and out_p must not change while out_valid=1 && !out_ready.
- Input sampling: inputs are sampled only at the accept edge. Changing in_a/in_b during RUN does not affect the result.
- Operand values: zero operands and 0xFF operands need no special case.
- SHORT_EN=0: the short flag is forced to 0.

Test Plan:
- Reset then in_a=0x12, in_b=0x34 accepted at T -> out_valid after edge T+4, out_p=0x03A8; in_ready=0 and busy=1 from T+1 until DONE is exited.
- in_a=0xFF, in_b=0xFF -> out_p=0xFE01 (max value, no truncation loss); in_a=0x00, in_b=0xAB -> out_p=0x0000 via the 4-step path.
- SHORT_EN=1, in_a=0x0F, in_b=0x0E -> out_p=0x00D2 after edge T+1. Repeat with SHORT_EN=0 -> same value after edge T+4.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_p and out_valid stable, in_ready=0, and in_valid pulses with new operands ignored. Then out_ready=1 for 1 cycle -> next cycle in_ready=1, out_valid=0.
- Reset mid-operation: assert rst during step2 of 0xA5*0x5A -> next cycle IDLE, out_valid=0, out_p=0. A fresh 0x03*0x07 then yields 0x0015 with no corruption.
- Back-to-back stream: 16 random operand pairs with out_ready held high, plus random out_ready stalls -> every product matches a*b, in order, none dropped or duplicated.

Source files
------------

// File: rtl/mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult8_seq_ctrl (+ 4x4 core "main")
// Brief    : Unsigned 8x8->16 multiplier built from one 4x4 core over 1-4 steps.
// Revision : 1.0
// ============================================================================

module main (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  assign o_p = {4'b0000, i_a} * {4'b0000, i_b};

endmodule

module mult8_seq_ctrl #(
  parameter int SHORT_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_step;
  logic        r_short;
  logic [7:0]  r_op_a;
  logic [7:0]  r_op_b;
  logic [15:0] r_acc;
  logic [15:0] r_out_p;
  logic        r_out_valid;

  logic [3:0]  w_core_a;
  logic [3:0]  w_core_b;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_shifted;
  logic [15:0] w_sum;
  logic        w_last;
  logic        w_accept;
  logic        w_short_ok;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_p     = r_out_p;
  assign w_accept  = in_valid && in_ready;

  generate
    if (SHORT_EN != 0) begin : g_short_en
      assign w_short_ok = (in_a[7:4] == 4'h0) && (in_b[7:4] == 4'h0);
    end else begin : g_short_dis
      assign w_short_ok = 1'b0;
    end
  endgenerate

  main u_core (
    .i_a (w_core_a),
    .i_b (w_core_b),
    .o_p (w_pp)
  );

  // Nibble selection and partial-product alignment for the current step.
  always_comb begin
    w_core_a     = r_op_a[3:0];
    w_core_b     = r_op_b[3:0];
    w_pp_shifted = {8'h00, w_pp};
    case (r_step)
      2'd0: begin
        w_core_a     = r_op_a[3:0];
        w_core_b     = r_op_b[3:0];
        w_pp_shifted = {8'h00, w_pp};
      end
      2'd1: begin
        w_core_a     = r_op_a[3:0];
        w_core_b     = r_op_b[7:4];
        w_pp_shifted = {4'h0, w_pp, 4'h0};
      end
      2'd2: begin
        w_core_a     = r_op_a[7:4];
        w_core_b     = r_op_b[3:0];
        w_pp_shifted = {4'h0, w_pp, 4'h0};
      end
      default: begin
        w_core_a     = r_op_a[7:4];
        w_core_b     = r_op_b[7:4];
        w_pp_shifted = {w_pp, 8'h00};
      end
    endcase
  end

  assign w_sum  = r_acc + w_pp_shifted;
  assign w_last = (r_step == 2'd3) || r_short;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step      <= 2'd0;
      r_short     <= 1'b0;
      r_op_a      <= 8'h00;
      r_op_b      <= 8'h00;
      r_acc       <= 16'h0000;
      r_out_p     <= 16'h0000;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a  <= in_a;
            r_op_b  <= in_b;
            r_acc   <= 16'h0000;
            r_step  <= 2'd0;
            r_short <= w_short_ok;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_out_p     <= w_sum;
            r_out_valid <= 1'b1;
          end else begin
            r_step <= r_step + 2'd1;
          end
        end
        S_DONE: begin
          // out_p stays put; only the handshake flag drops on acknowledge.
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult8_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult8_seq_ctrl
// Brief    : Directed bench for mult8_seq_ctrl, fast-path and four-step builds.
// Revision : 1.0
// ============================================================================

module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_ready;
  logic        sel_f;

  logic        s_in_ready, s_out_valid, s_busy;
  logic [15:0] s_out_p;
  logic        f_in_ready, f_out_valid, f_busy;
  logic [15:0] f_out_p;

  logic        w_in_ready, w_out_valid, w_busy;
  logic [15:0] w_out_p;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mult8_seq_ctrl #(.SHORT_EN(1)) dut_s (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && !sel_f),
    .in_ready  (s_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_p     (s_out_p),
    .busy      (s_busy)
  );

  mult8_seq_ctrl #(.SHORT_EN(0)) dut_f (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid && sel_f),
    .in_ready  (f_in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (f_out_valid),
    .out_ready (out_ready),
    .out_p     (f_out_p),
    .busy      (f_busy)
  );

  assign w_in_ready  = sel_f ? f_in_ready  : s_in_ready;
  assign w_out_valid = sel_f ? f_out_valid : s_out_valid;
  assign w_busy      = sel_f ? f_busy      : s_busy;
  assign w_out_p     = sel_f ? f_out_p     : s_out_p;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands for one edge, then scramble the bus to prove sampling.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    int k;
    k = 0;
    while (!w_in_ready && k < 20) begin
      tick();
      k++;
    end
    chk("in_ready_before_accept", {31'b0, w_in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a     = 8'($urandom);
    in_b     = 8'($urandom);
  endtask

  task automatic wait_result(input string tag, input int exp_lat, input logic [15:0] exp_p);
    int lat;
    lat = 0;
    while (lat < 12) begin
      chk({tag, "_busy"}, {31'b0, w_busy}, 32'd1);
      chk({tag, "_in_ready_low"}, {31'b0, w_in_ready}, 32'd0);
      tick();
      lat++;
      if (w_out_valid) break;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_out_valid"}, {31'b0, w_out_valid}, 32'd1);
    chk({tag, "_product"}, {16'b0, w_out_p}, {16'b0, exp_p});
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ack_out_valid"}, {31'b0, w_out_valid}, 32'd0);
    chk({tag, "_ack_in_ready"}, {31'b0, w_in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0]  a, b;
    logic [15:0] p_hold;
    int          exp_lat;
    int          stall;

    rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    out_ready = 1'b0; sel_f = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, w_in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, w_out_valid}, 32'd0);
    chk("rst_out_p", {16'b0, w_out_p}, 32'h0);
    chk("rst_busy", {31'b0, w_busy}, 32'd0);

    start_op(8'h12, 8'h34);
    wait_result("p12x34", 4, 16'h03A8);
    tick();
    chk("p12x34_held_busy", {31'b0, w_busy}, 32'd1);
    chk("p12x34_held_in_ready", {31'b0, w_in_ready}, 32'd0);
    ack("p12x34");

    start_op(8'hFF, 8'hFF);
    wait_result("pFFxFF", 4, 16'hFE01);
    ack("pFFxFF");

    start_op(8'h00, 8'hAB);
    wait_result("p00xAB", 4, 16'h0000);
    ack("p00xAB");

    start_op(8'h0F, 8'h0E);
    wait_result("short_0Fx0E", 1, 16'h00D2);
    ack("short_0Fx0E");

    sel_f = 1'b1;
    start_op(8'h0F, 8'h0E);
    wait_result("full_0Fx0E", 4, 16'h00D2);
    ack("full_0Fx0E");
    sel_f = 1'b0;

    // Back-pressure with intruding operands that must be ignored.
    start_op(8'h9C, 8'h37);
    wait_result("bp_9Cx37", 4, 16'h2184);
    for (int i = 0; i < 5; i++) begin
      in_a = 8'h11; in_b = 8'h22; in_valid = (i % 2 == 0);
      tick();
      chk("bp_out_p_stable", {16'b0, w_out_p}, 32'h2184);
      chk("bp_out_valid_stable", {31'b0, w_out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'b0, w_in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    ack("bp_9Cx37");
    start_op(8'h21, 8'h10);
    wait_result("after_bp_21x10", 4, 16'h0210);
    ack("after_bp_21x10");

    // Reset while step 2 is in flight.
    start_op(8'hA5, 8'h5A);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", {31'b0, w_in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, w_out_valid}, 32'd0);
    chk("midrst_out_p", {16'b0, w_out_p}, 32'h0);
    chk("midrst_busy", {31'b0, w_busy}, 32'd0);
    start_op(8'h03, 8'h07);
    wait_result("midrst_03x07", 1, 16'h0015);
    ack("midrst_03x07");

    // Stream of random pairs with occasional consumer stalls.
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (i % 4 == 1) a[7:4] = 4'h0;
      if (i % 4 == 1) b[7:4] = 4'h0;
      exp_lat = (a[7:4] == 4'h0 && b[7:4] == 4'h0) ? 1 : 4;
      out_ready = (i % 2 == 0);
      start_op(a, b);
      wait_result("stream", exp_lat, 16'(a) * 16'(b));
      if (!out_ready) begin
        stall  = $urandom_range(0, 3);
        p_hold = w_out_p;
        for (int j = 0; j < stall; j++) begin
          tick();
          chk("stream_stall_out_p", {16'b0, w_out_p}, {16'b0, p_hold});
        end
      end
      ack("stream");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
